// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: stage state encoding,
// occupancy codes and the state-to-occupancy decode.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Number of beats held by the stage in a given state.
  function automatic logic [1:0] state_to_occ(input stage_state_t s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = OCC_EMPTY;
      ONE:     occ = OCC_ONE;
      FULL:    occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// optional two-entry skid buffer and synchronous flush to a bubble.
// The control bundle is held zeroed whenever the stage is empty so that
// a bubble can never retrigger side effects downstream.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = 8,
  parameter int DATA_W  = 64,
  parameter int SKID_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  stage_state_t      state_q, state_d;
  logic              valid_q, valid_d;
  logic [1:0]        occ_q, occ_d;
  logic              rdy_q, rdy_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;

  // Upstream ready: registered in skid mode, pass-through of downstream space otherwise.
  always_comb begin
    in_ready_s = 1'b0;
    if (SKID_EN != 0) begin
      in_ready_s = rdy_q;
    end else begin
      in_ready_s = ~valid_q | (out_ready_i & ~stall_i);
    end
  end

  assign in_fire_s  = in_valid_i & in_ready_s;
  assign out_fire_s = valid_q & out_ready_i & ~stall_i;

  // Next-state and entry update; flush overrides any transfer in the same cycle.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (in_fire_s) begin
          state_d = ONE;
          ctrl_d  = in_ctrl_i;
          data_d  = in_data_i;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (in_fire_s && out_fire_s) begin
          state_d = ONE;
          ctrl_d  = in_ctrl_i;
          data_d  = in_data_i;
        end else if (in_fire_s) begin
          if (SKID_EN != 0) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
          end else begin
            // Without a skid entry upstream only fires when the output drains.
            state_d = ONE;
            ctrl_d  = in_ctrl_i;
            data_d  = in_data_i;
          end
        end else if (out_fire_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      FULL: begin
        if (out_fire_s) begin
          state_d = ONE;
          ctrl_d  = skid_ctrl_q;
          data_d  = skid_data_q;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush_i) begin
      // Drop the arriving beat and any skid content; data keeps its last value.
      state_d     = EMPTY;
      ctrl_d      = ctrl_q;
      data_d      = data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
    end else begin
      state_d = state_d;
    end

    // A bubble always presents an all-zero control bundle.
    if (state_d == EMPTY) begin
      ctrl_d = {CTRL_W{1'b0}};
    end else begin
      ctrl_d = ctrl_d;
    end

    valid_d = (state_d != EMPTY);
    occ_d   = state_to_occ(state_d);
    rdy_d   = (state_d != FULL);
  end

  // Stage state, entries and registered output flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      occ_q       <= OCC_EMPTY;
      rdy_q       <= 1'b1;
      ctrl_q      <= {CTRL_W{1'b0}};
      data_q      <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      rdy_q       <= rdy_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = valid_q;
  assign out_ctrl_o  = ctrl_q;
  assign out_data_o  = data_q;
  assign occ_o       = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives a skid-mode and a pass-mode instance with
// identical stimulus and compares both against FIFO reference models.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, stall_i, in_valid_i, out_ready_i;
  logic [7:0]  in_ctrl_i;
  logic [63:0] in_data_i;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [7:0]  out_ctrl0, out_ctrl1;
  logic [63:0] out_data0, out_data1;
  logic [1:0]  occ0, occ1;

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } beat_t;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [63:0] ld0, ld1;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .SKID_EN(1)) u_skid (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready0), .in_ctrl_i(in_ctrl_i),
    .in_data_i(in_data_i), .out_valid_o(out_valid0), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl0), .out_data_o(out_data0), .occ_o(occ0));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .SKID_EN(0)) u_pass (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready1), .in_ctrl_i(in_ctrl_i),
    .in_data_i(in_data_i), .out_valid_o(out_valid1), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl1), .out_data_o(out_data1), .occ_o(occ1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [63:0] d,
                       input logic ordy, input logic st, input logic fl);
    in_valid_i  = v;
    in_ctrl_i   = c;
    in_data_i   = d;
    out_ready_i = ordy;
    stall_i     = st;
    flush_i     = fl;
  endtask

  // Compare every output of both instances with the reference queues.
  task automatic check_all();
    logic [7:0] e0c, e1c;
    e0c = 8'h00;
    e1c = 8'h00;
    if (q0.size() > 0) e0c = q0[0].c;
    if (q1.size() > 0) e1c = q1[0].c;
    chk("skid_valid", {63'd0, out_valid0}, {63'd0, q0.size() > 0});
    chk("skid_ctrl",  {56'd0, out_ctrl0}, {56'd0, e0c});
    chk("skid_data",  out_data0, ld0);
    chk("skid_occ",   {62'd0, occ0}, 64'(q0.size()));
    chk("skid_ready", {63'd0, in_ready0}, {63'd0, q0.size() < 2});
    chk("pass_valid", {63'd0, out_valid1}, {63'd0, q1.size() > 0});
    chk("pass_ctrl",  {56'd0, out_ctrl1}, {56'd0, e1c});
    chk("pass_data",  out_data1, ld1);
    chk("pass_occ",   {62'd0, occ1}, 64'(q1.size()));
    chk("pass_ready", {63'd0, in_ready1},
        {63'd0, (q1.size() == 0) || (out_ready_i && !stall_i)});
  endtask

  // Apply one clock edge of the reference behaviour to both queues.
  task automatic model_step();
    bit    r0, r1, i0, i1, o0, o1;
    beat_t b;
    if (rst_i) begin
      q0.delete(); q1.delete(); ld0 = 64'd0; ld1 = 64'd0;
    end else begin
      b.c = in_ctrl_i;
      b.d = in_data_i;
      r0 = q0.size() < 2;
      r1 = (q1.size() == 0) || (out_ready_i && !stall_i);
      i0 = in_valid_i && r0;
      i1 = in_valid_i && r1;
      o0 = (q0.size() > 0) && out_ready_i && !stall_i;
      o1 = (q1.size() > 0) && out_ready_i && !stall_i;
      if (flush_i) begin
        q0.delete(); q1.delete();
      end else begin
        if (o0) void'(q0.pop_front());
        if (i0) q0.push_back(b);
        if (o1) void'(q1.pop_front());
        if (i1) q1.push_back(b);
      end
      if (q0.size() > 0) ld0 = q0[0].d;
      if (q1.size() > 0) ld1 = q1[0].d;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ld0 = 64'd0;
    ld1 = 64'd0;
    rst_i = 1'b1;
    drive(1'b1, 8'h77, 64'h77, 1'b1, 1'b0, 1'b0);  // handshake ignored in reset
    cycle();
    cycle();
    rst_i = 1'b0;

    // Stream 01..05 with downstream always ready.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'(i), 64'h100 + 64'(i), 1'b1, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    cycle();

    // Stall absorb: A held, B in skid.
    drive(1'b1, 8'hA1, 64'hAAAA, 1'b1, 1'b1, 1'b0); cycle();
    drive(1'b1, 8'hB2, 64'hBBBB, 1'b1, 1'b1, 1'b0); cycle();
    chk("absorb_occ", {62'd0, occ0}, 64'd2);
    chk("absorb_rdy", {63'd0, in_ready0}, 64'd0);
    chk("absorb_ctrl", {56'd0, out_ctrl0}, 64'hA1);
    drive(1'b1, 8'hC3, 64'hCCCC, 1'b1, 1'b1, 1'b0); cycle();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 1'b0); cycle();
    chk("release_b", {56'd0, out_ctrl0}, 64'hB2);
    cycle();
    cycle();

    // Flush while FULL with a beat offered.
    drive(1'b1, 8'hD1, 64'hD1, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b1, 8'hD2, 64'hD2, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b1, 8'hEE, 64'hEE, 1'b1, 1'b0, 1'b1); cycle();
    chk("flush_valid", {63'd0, out_valid0}, 64'd0);
    chk("flush_ctrl", {56'd0, out_ctrl0}, 64'd0);
    chk("flush_occ", {62'd0, occ0}, 64'd0);
    drive(1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 1'b0); cycle();

    // Bubble keeps data, zeroes control.
    drive(1'b1, 8'h55, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bubble_data", out_data0, 64'hDEAD_BEEF);
      chk("bubble_ctrl", {56'd0, out_ctrl0}, 64'd0);
      chk("bubble_pdata", out_data1, 64'hDEAD_BEEF);
    end

    // Asynchronous reset while FULL, between clock edges.
    drive(1'b1, 8'h91, 64'h91, 1'b1, 1'b1, 1'b0); cycle();
    drive(1'b1, 8'h92, 64'h92, 1'b1, 1'b1, 1'b0); cycle();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b0);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_valid", {63'd0, out_valid0}, 64'd0);
    chk("arst_ctrl", {56'd0, out_ctrl0}, 64'd0);
    chk("arst_data", out_data0, 64'd0);
    chk("arst_occ", {62'd0, occ0}, 64'd0);
    chk("arst_rdy", {63'd0, in_ready0}, 64'd1);
    rst_i = 1'b0;
    q0.delete(); q1.delete(); ld0 = 64'd0; ld1 = 64'd0;
    drive(1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 1'b0);
    cycle();

    // Pass mode: in_ready follows out_ready within the same cycle.
    drive(1'b1, 8'h61, 64'h61, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 1'b0);
    #1 chk("pass_trk1", {63'd0, in_ready1}, 64'd1);
    out_ready_i = 1'b0;
    #1 chk("pass_trk0", {63'd0, in_ready1}, 64'd0);
    out_ready_i = 1'b1;
    #1 chk("pass_trk1b", {63'd0, in_ready1}, 64'd1);
    cycle();

    // Randomised traffic against the reference queues.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), {$urandom, $urandom},
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 5);
      cycle();
    end
    drive(1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
